// File: rtl/dds_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dds_ctrl_pkg
//   Shared types and default widths for the DDS frequency-sweep controller.
//   - mode_t  : sweep mode as encoded on io_cfg_mode
//               (RSVD behaves like SINGLE)
//   - state_t : sweep sequencer state
//   - FTW_W / CNT_W : default tuning-word and counter widths
// -----------------------------------------------------------------------------
package dds_ctrl_pkg;

  localparam int FTW_W = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    SINGLE   = 2'd0,
    REPEAT   = 2'd1,
    TRIANGLE = 2'd2,
    RSVD     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

endpackage : dds_ctrl_pkg

// File: rtl/dds_dwell_timer.sv
// -----------------------------------------------------------------------------
// dds_dwell_timer
//   Loadable down-counter that measures how long each sweep point is held.
//   A load sets the count to max(dwell,1)-1; while enabled the count walks
//   down to 0, and o_expire is high in the last cycle of the dwell.
//
//   Ports
//     i_clk     : clock, rising edge
//     i_rst_n   : asynchronous active-low reset
//     i_load    : reload the counter from i_dwell (wins over counting)
//     i_dwell   : dwell length in cycles, 0 treated as 1
//     i_enable  : counting enabled (sweep running)
//     o_expire  : last cycle of the current dwell
// -----------------------------------------------------------------------------
module dds_dwell_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_dwell,
  input  logic         i_enable,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_reload;

  // A dwell of 0 behaves exactly like a dwell of 1.
  assign w_reload = (i_dwell == '0) ? '0 : i_dwell - W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_reload;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expire = i_enable && (r_cnt == '0);

endmodule : dds_dwell_timer

// File: rtl/dds_sweep_controller.sv
// -----------------------------------------------------------------------------
// dds_sweep_controller
//   Frequency-sweep sequencer driving the tuning word of the DDS. A start in
//   IDLE captures the sweep configuration into shadow registers, then the
//   tuning word steps linearly, each point held for max(dwell,1) cycles, in
//   SINGLE, REPEAT or TRIANGLE mode. All outputs are registered.
//
//   Handshake: io_start is a one-cycle request that is only looked at in IDLE
//   (the cycle io_done is high is IDLE, so back-to-back starts work);
//   io_abort is only looked at while busy, and a start+abort in IDLE starts.
//
//   Ports
//     clock / reset        : rising-edge clock, async active-low reset
//     io_start, io_abort   : sweep control
//     io_cfg_*             : sweep configuration, sampled on an accepted start
//     io_ftw               : tuning word to the DDS io_A input
//     io_step_strobe       : high in each cycle io_ftw takes a new point
//     io_index             : current point index
//     io_busy, io_done     : status; done is a one-cycle completion pulse
//     io_dbg_state         : current sequencer state (state_t encoding)
// -----------------------------------------------------------------------------
module dds_sweep_controller
  import dds_ctrl_pkg::*;
#(
  parameter int g_accWidth = FTW_W,
  parameter int g_cntWidth = CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic                  io_abort,
  input  logic [g_accWidth-1:0] io_cfg_ftw_start,
  input  logic [g_accWidth-1:0] io_cfg_ftw_step,
  input  logic [g_cntWidth-1:0] io_cfg_num_steps,
  input  logic [g_cntWidth-1:0] io_cfg_dwell,
  input  logic [1:0]            io_cfg_mode,
  output logic [g_accWidth-1:0] io_ftw,
  output logic                  io_step_strobe,
  output logic [g_cntWidth-1:0] io_index,
  output logic                  io_busy,
  output logic                  io_done,
  output logic [1:0]            io_dbg_state
);

  // Sequencer state and registered outputs
  state_t                r_state;
  logic [g_accWidth-1:0] r_ftw;
  logic [g_cntWidth-1:0] r_index;
  logic                  r_strobe;
  logic                  r_busy;
  logic                  r_done;

  // Shadow configuration, captured on an accepted start
  logic [g_accWidth-1:0] r_start;
  logic [g_accWidth-1:0] r_step;
  logic [g_cntWidth-1:0] r_num_steps;
  logic [g_cntWidth-1:0] r_dwell;
  mode_t                 r_mode;

  logic                  w_take_start;
  logic                  w_expire;
  logic                  w_timer_load;
  logic                  w_timer_en;
  logic [g_cntWidth-1:0] w_timer_dwell;

  assign w_take_start = (r_state == IDLE) && io_start;

  // The first dwell is loaded straight from the config inputs because the
  // shadow registers are only being written on that same edge. Reloading on
  // every expiry is harmless when the sweep ends, since the timer is then
  // disabled.
  assign w_timer_dwell = (r_state == IDLE) ? io_cfg_dwell : r_dwell;
  assign w_timer_load  = w_take_start || w_expire;
  assign w_timer_en    = (r_state != IDLE);

  dds_dwell_timer #(
    .W (g_cntWidth)
  ) u_dwell_timer (
    .i_clk    (clock),
    .i_rst_n  (reset),
    .i_load   (w_timer_load),
    .i_dwell  (w_timer_dwell),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ftw       <= '0;
      r_index     <= '0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_start     <= '0;
      r_step      <= '0;
      r_num_steps <= '0;
      r_dwell     <= '0;
      r_mode      <= SINGLE;
    end else begin
      // Pulses default low; set only in the cycle they apply to.
      r_strobe <= 1'b0;
      r_done   <= 1'b0;

      case (r_state)
        IDLE: begin
          // io_ftw holds its last value here so the DDS keeps running.
          if (io_start) begin
            r_start     <= io_cfg_ftw_start;
            r_step      <= io_cfg_ftw_step;
            r_num_steps <= io_cfg_num_steps;
            r_dwell     <= io_cfg_dwell;
            r_mode      <= mode_t'(io_cfg_mode);
            r_state     <= UP;
            r_index     <= '0;
            r_ftw       <= io_cfg_ftw_start;
            r_busy      <= 1'b1;
            r_strobe    <= 1'b1;
          end
        end

        UP: begin
          if (io_abort) begin
            // A zero tuning word freezes the DDS phase.
            r_state <= IDLE;
            r_ftw   <= '0;
            r_busy  <= 1'b0;
          end else if (w_expire) begin
            if (r_index < r_num_steps) begin
              r_index  <= r_index + g_cntWidth'(1);
              r_ftw    <= r_ftw + r_step;
              r_strobe <= 1'b1;
            end else begin
              case (r_mode)
                REPEAT: begin
                  r_index  <= '0;
                  r_ftw    <= r_start;
                  r_strobe <= 1'b1;
                end
                TRIANGLE: begin
                  if (r_num_steps != '0) begin
                    r_state  <= DOWN;
                    r_index  <= r_index - g_cntWidth'(1);
                    r_ftw    <= r_ftw - r_step;
                    r_strobe <= 1'b1;
                  end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                end
                default: begin
                  // SINGLE and the reserved encoding finish here.
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              endcase
            end
          end
        end

        DOWN: begin
          if (io_abort) begin
            r_state <= IDLE;
            r_ftw   <= '0;
            r_busy  <= 1'b0;
          end else if (w_expire) begin
            if (r_index != '0) begin
              r_index  <= r_index - g_cntWidth'(1);
              r_ftw    <= r_ftw - r_step;
              r_strobe <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_ftw         = r_ftw;
  assign io_step_strobe = r_strobe;
  assign io_index       = r_index;
  assign io_busy        = r_busy;
  assign io_done        = r_done;
  assign io_dbg_state   = r_state;

endmodule : dds_sweep_controller

// File: tb/tb_dds_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_controller
//   Directed bench for dds_sweep_controller. Inputs change and outputs are
//   sampled 1 time unit after each rising edge; expected values are written
//   out by hand from the sweep definitions.
// -----------------------------------------------------------------------------
module tb_dds_sweep_controller;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic        io_abort;
  logic [31:0] io_cfg_ftw_start;
  logic [31:0] io_cfg_ftw_step;
  logic [15:0] io_cfg_num_steps;
  logic [15:0] io_cfg_dwell;
  logic [1:0]  io_cfg_mode;
  logic [31:0] io_ftw;
  logic        io_step_strobe;
  logic [15:0] io_index;
  logic        io_busy;
  logic        io_done;
  logic [1:0]  io_dbg_state;

  int n_vec;
  int n_err;

  dds_sweep_controller dut (
    .clock            (clock),
    .reset            (reset),
    .io_start         (io_start),
    .io_abort         (io_abort),
    .io_cfg_ftw_start (io_cfg_ftw_start),
    .io_cfg_ftw_step  (io_cfg_ftw_step),
    .io_cfg_num_steps (io_cfg_num_steps),
    .io_cfg_dwell     (io_cfg_dwell),
    .io_cfg_mode      (io_cfg_mode),
    .io_ftw           (io_ftw),
    .io_step_strobe   (io_step_strobe),
    .io_index         (io_index),
    .io_busy          (io_busy),
    .io_done          (io_done),
    .io_dbg_state     (io_dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] st,
                         input logic [15:0] n, input logic [15:0] dw,
                         input logic [1:0] m);
    io_cfg_ftw_start = s;
    io_cfg_ftw_step  = st;
    io_cfg_num_steps = n;
    io_cfg_dwell     = dw;
    io_cfg_mode      = m;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pt(input string tag, input logic [31:0] ftw,
                          input logic [15:0] idx, input logic strb,
                          input logic bsy, input logic dn);
    check({tag, ".ftw"},    io_ftw,                 ftw);
    check({tag, ".index"},  {16'd0, io_index},      {16'd0, idx});
    check({tag, ".strobe"}, {31'd0, io_step_strobe}, {31'd0, strb});
    check({tag, ".busy"},   {31'd0, io_busy},       {31'd0, bsy});
    check({tag, ".done"},   {31'd0, io_done},       {31'd0, dn});
  endtask

  logic [31:0] tri_ftw [5];
  logic [15:0] tri_idx [5];
  logic [31:0] rep_ftw [6];
  logic [15:0] rep_idx [6];

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    io_start = 1'b0;
    io_abort = 1'b0;
    set_cfg(32'd0, 32'd0, 16'd0, 16'd0, 2'd0);
    tri_ftw = '{32'd0, 32'd5, 32'd10, 32'd5, 32'd0};
    tri_idx = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd0};
    rep_ftw = '{32'd7, 32'd7, 32'd8, 32'd8, 32'd7, 32'd7};
    rep_idx = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0};

    // Reset state
    #2;
    check_pt("reset", 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    check("reset.state", {30'd0, io_dbg_state}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_pt("idle", 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // SINGLE: 1000/1100/1200/1300, 4 cycles each, then done
    set_cfg(32'd1000, 32'd100, 16'd3, 16'd4, 2'd0);
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int d = 0; d < 4; d++) begin
        // Start with different cfg while busy must be ignored
        io_start = (p == 1 && d == 1);
        if (p == 1 && d == 1) set_cfg(32'd55, 32'd1, 16'd0, 16'd1, 2'd0);
        check_pt($sformatf("single.p%0d.d%0d", p, d), 32'd1000 + 32'(100 * p),
                 16'(p), (d == 0), 1'b1, 1'b0);
        tick();
        io_start = 1'b0;
      end
    end
    check_pt("single.done", 32'd1300, 16'd3, 1'b0, 1'b0, 1'b1);
    tick();
    check_pt("single.after", 32'd1300, 16'd3, 1'b0, 1'b0, 1'b0);

    // TRIANGLE: 0,5,10,5,0 with dwell 1
    set_cfg(32'd0, 32'd5, 16'd2, 16'd1, 2'd2);
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_pt($sformatf("tri.%0d", i), tri_ftw[i], tri_idx[i], 1'b1, 1'b1, 1'b0);
      if (i == 1) check("tri.state_up", {30'd0, io_dbg_state}, 32'd1);
      if (i == 3) check("tri.state_down", {30'd0, io_dbg_state}, 32'd2);
      tick();
    end
    check_pt("tri.done", 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Back-to-back start in the done cycle: wrap with zero dwell
    set_cfg(32'hFFFF_FFF0, 32'h20, 16'd1, 16'd0, 2'd0);
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    check_pt("wrap.0", 32'hFFFF_FFF0, 16'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_pt("wrap.1", 32'h0000_0010, 16'd1, 1'b1, 1'b1, 1'b0);
    tick();
    check_pt("wrap.done", 32'h0000_0010, 16'd1, 1'b0, 1'b0, 1'b1);
    tick();

    // REPEAT 7,7,8,8,7,7,8 then abort at the start of a point
    set_cfg(32'd7, 32'd1, 16'd1, 16'd2, 2'd1);
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_pt($sformatf("rep.%0d", i), rep_ftw[i], rep_idx[i],
               (i % 2 == 0), 1'b1, 1'b0);
      tick();
    end
    check_pt("rep.6", 32'd8, 16'd1, 1'b1, 1'b1, 1'b0);
    io_abort = 1'b1;
    tick();
    check("abort.ftw",    io_ftw,                  32'd0);
    check("abort.busy",   {31'd0, io_busy},        32'd0);
    check("abort.done",   {31'd0, io_done},        32'd0);
    check("abort.strobe", {31'd0, io_step_strobe}, 32'd0);
    // Abort held in IDLE has no effect
    tick();
    io_abort = 1'b0;
    check("abort_idle.busy", {31'd0, io_busy}, 32'd0);
    check("abort_idle.done", {31'd0, io_done}, 32'd0);
    check("abort_idle.ftw",  io_ftw,           32'd0);

    // Start together with abort in IDLE: start wins
    set_cfg(32'd1000, 32'd100, 16'd3, 16'd4, 2'd0);
    io_start = 1'b1;
    io_abort = 1'b1;
    tick();
    io_start = 1'b0;
    io_abort = 1'b0;
    check_pt("start_abort", 32'd1000, 16'd0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check_pt("pre_reset", 32'd1100, 16'd1, 1'b1, 1'b1, 1'b0);

    // Async reset between edges
    #2;
    reset = 1'b0;
    #1;
    check_pt("async_reset", 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    check("async_reset.state", {30'd0, io_dbg_state}, 32'd0);
    #1;
    reset = 1'b1;
    tick();
    check_pt("post_reset.idle", 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    // New sweep after reset
    set_cfg(32'd42, 32'd3, 16'd1, 16'd1, 2'd3);
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    check_pt("post.0", 32'd42, 16'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_pt("post.1", 32'd45, 16'd1, 1'b1, 1'b1, 1'b0);
    tick();
    check_pt("post.done", 32'd45, 16'd1, 1'b0, 1'b0, 1'b1);
    tick();
    check_pt("post.idle", 32'd45, 16'd1, 1'b0, 1'b0, 1'b0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dds_sweep_controller
